// File: rtl/mlp_pkg.sv
// Shared types for the MLP layer sequencer: FSM states, drain timing and the issue-stage flag bundle.
package mlp_pkg;

  localparam int SEQ_SIZE_BITS = 6;
  localparam int DRAIN_CYCLES  = 2;
  localparam int DRAIN_BITS    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE,
    ERR
  } seq_state_t;

  typedef struct packed {
    logic                     first_col;
    logic                     last_col;
    logic [SEQ_SIZE_BITS-1:0] row;
  } issue_flags_t;

endpackage

// File: rtl/mlp_seq_counter.sv
// Nested col/row counter; col is the inner loop and wraps into a row increment.
module mlp_seq_counter #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_advance,
  input  logic [W-1:0] i_col_last,
  input  logic [W-1:0] i_row_last,
  output logic [W-1:0] o_col,
  output logic [W-1:0] o_row,
  output logic         o_col_wrap,
  output logic         o_row_wrap
);

  localparam logic [W-1:0] ONE = 1;

  logic [W-1:0] r_col;
  logic [W-1:0] r_row;

  assign o_col      = r_col;
  assign o_row      = r_row;
  assign o_col_wrap = (r_col == i_col_last);
  assign o_row_wrap = (r_row == i_row_last);

  // Wrapping the last row back to 0 leaves the counter ready for the next layer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_advance) begin
      if (o_col_wrap) begin
        r_col <= '0;
        r_row <= o_row_wrap ? '0 : r_row + ONE;
      end else begin
        r_col <= r_col + ONE;
      end
    end
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Control FSM walking every MLP layer row-by-row, col-by-col and driving BRAM/MAC strobes.
// Define MLP_SEQ_PERF_EN to build the perf_cycles run-length counter; otherwise it reads 0.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int NUM_LAYERS       = 2,
  parameter int MAX_COL_ROW_BITS = SEQ_SIZE_BITS,
  parameter int MAX_COL_ROWS     = 9,
  parameter int LAYER_BITS       = 2,
  parameter int WADDR_WIDTH      = 8
) (
  input  logic                                        i_clk,
  input  logic                                        i_rst,
  input  logic                                        i_new_data,
  input  logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0] i_all_rows_sizes,
  input  logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0] i_all_cols_sizes,
  output logic                                        o_busy,
  output logic                                        o_w_rd_en,
  output logic [WADDR_WIDTH-1:0]                      o_w_addr,
  output logic [MAX_COL_ROW_BITS-1:0]                 o_act_rd_addr,
  output logic                                        o_act_bank,
  output logic [LAYER_BITS-1:0]                       o_layer_idx,
  output logic                                        o_mac_en,
  output logic                                        o_acc_clr,
  output logic                                        o_acc_commit,
  output logic [MAX_COL_ROW_BITS-1:0]                 o_out_wr_addr,
  output logic                                        o_output_ready,
  output logic                                        o_cfg_err,
  output logic [31:0]                                 o_perf_cycles
);

  localparam logic [MAX_COL_ROW_BITS-1:0] SIZE_ONE = 1;
  localparam logic [MAX_COL_ROW_BITS-1:0] SIZE_MAX = MAX_COL_ROW_BITS'(MAX_COL_ROWS);

  seq_state_t r_state;
  seq_state_t w_nextState;

  logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0] r_rows;
  logic [NUM_LAYERS-1:0][MAX_COL_ROW_BITS-1:0] r_cols;
  logic [WADDR_WIDTH-1:0]      r_wAddr;
  logic [LAYER_BITS-1:0]       r_layer;
  logic [DRAIN_BITS-1:0]       r_drainCnt;
  issue_flags_t                r_issueDly;
  logic                        r_macEn;
  logic                        r_outputReady;
  logic                        r_cfgErr;

  logic [MAX_COL_ROW_BITS-1:0] w_curRows;
  logic [MAX_COL_ROW_BITS-1:0] w_curCols;
  logic [MAX_COL_ROW_BITS-1:0] w_col;
  logic [MAX_COL_ROW_BITS-1:0] w_row;
  logic                        w_colWrap;
  logic                        w_rowWrap;
  logic                        w_cfgBad;
  logic                        w_drainDone;
  logic                        w_lastLayer;
  issue_flags_t                w_issue;

  // Sizes of the layer currently being walked.
  always_comb begin
    w_curRows = '0;
    w_curCols = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (r_layer == LAYER_BITS'(l)) begin
        w_curRows = r_rows[l];
        w_curCols = r_cols[l];
      end
    end
  end

  // Checked against the live inputs while in LOAD, i.e. the same values being latched.
  always_comb begin
    w_cfgBad = 1'b0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (i_all_rows_sizes[l] == '0 || i_all_cols_sizes[l] == '0 ||
          i_all_rows_sizes[l] > SIZE_MAX || i_all_cols_sizes[l] > SIZE_MAX)
        w_cfgBad = 1'b1;
    end
    for (int l = 0; l < NUM_LAYERS - 1; l++) begin
      if (i_all_cols_sizes[l+1] != i_all_rows_sizes[l])
        w_cfgBad = 1'b1;
    end
  end

  mlp_seq_counter #(.W(MAX_COL_ROW_BITS)) u_counter (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (r_state == LOAD),
    .i_advance  (r_state == RUN),
    .i_col_last (w_curCols - SIZE_ONE),
    .i_row_last (w_curRows - SIZE_ONE),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_col_wrap (w_colWrap),
    .o_row_wrap (w_rowWrap)
  );

  assign w_drainDone = (r_drainCnt == DRAIN_BITS'(DRAIN_CYCLES - 1));
  assign w_lastLayer = (r_layer == LAYER_BITS'(NUM_LAYERS - 1));

  always_comb begin
    w_issue.first_col = (w_col == '0);
    w_issue.last_col  = w_colWrap;
    w_issue.row       = SEQ_SIZE_BITS'(w_row);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_new_data) w_nextState = LOAD;
      LOAD:    w_nextState = w_cfgBad ? ERR : RUN;
      RUN:     if (w_colWrap && w_rowWrap) w_nextState = DRAIN;
      DRAIN:   if (w_drainDone) w_nextState = w_lastLayer ? DONE : RUN;
      DONE:    w_nextState = IDLE;
      ERR:     w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Terminal pulses are registered so they land in the first IDLE cycle, together with busy dropping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rows        <= '0;
      r_cols        <= '0;
      r_wAddr       <= '0;
      r_layer       <= '0;
      r_drainCnt    <= '0;
      r_issueDly    <= '0;
      r_macEn       <= 1'b0;
      r_outputReady <= 1'b0;
      r_cfgErr      <= 1'b0;
    end else begin
      r_outputReady <= (r_state == DONE);
      r_cfgErr      <= (r_state == ERR);
      r_macEn       <= (r_state == RUN);
      r_issueDly    <= (r_state == RUN) ? w_issue : '0;
      r_drainCnt    <= (r_state == DRAIN) ? r_drainCnt + DRAIN_BITS'(1) : '0;
      case (r_state)
        LOAD: begin
          r_rows  <= i_all_rows_sizes;
          r_cols  <= i_all_cols_sizes;
          r_wAddr <= '0;
          r_layer <= '0;
        end
        RUN:   r_wAddr <= r_wAddr + WADDR_WIDTH'(1);
        DRAIN: if (w_drainDone && !w_lastLayer) r_layer <= r_layer + LAYER_BITS'(1);
        default: ;
      endcase
    end
  end

`ifdef MLP_SEQ_PERF_EN
  logic [31:0] r_perf;

  // Counts every non-IDLE cycle of a run and holds the result until the next start.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                              r_perf <= '0;
    else if (r_state == IDLE && i_new_data) r_perf <= '0;
    else if (r_state != IDLE)               r_perf <= r_perf + 32'd1;
  end

  assign o_perf_cycles = r_perf;
`else
  assign o_perf_cycles = '0;
`endif

  assign o_busy         = (r_state != IDLE);
  assign o_w_rd_en      = (r_state == RUN);
  assign o_w_addr       = r_wAddr;
  assign o_act_rd_addr  = w_col;
  assign o_act_bank     = r_layer[0];
  assign o_layer_idx    = r_layer;
  assign o_mac_en       = r_macEn;
  assign o_acc_clr      = r_issueDly.first_col;
  assign o_acc_commit   = r_issueDly.last_col;
  assign o_out_wr_addr  = MAX_COL_ROW_BITS'(r_issueDly.row);
  assign o_output_ready = r_outputReady;
  assign o_cfg_err      = r_cfgErr;

endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Self-checking bench for mlp_layer_sequencer: directed and random layer configurations
// compared cycle-by-cycle against a loop-nest model of the layer walk.
module tb_mlp_layer_sequencer;

  logic            clk = 1'b0;
  logic            rst;
  logic            newData;
  logic [1:0][5:0] rowsIn;
  logic [1:0][5:0] colsIn;
  logic            busy, wRdEn, actBank, macEn, accClr, accCommit, outputReady, cfgErr;
  logic [7:0]      wAddr;
  logic [5:0]      actRdAddr, outWrAddr;
  logic [1:0]      layerIdx;
  logic [31:0]     perfCycles;

  int vectors    = 0;
  int miscompares = 0;

  int cfgRows[2];
  int cfgCols[2];
  int lat;
  bit expRd[256];
  bit expFirst[256];
  bit expLast[256];
  int expAddr[256];
  int expCol[256];
  int expLayer[256];
  int expRow[256];

  always #5 clk = ~clk;

  mlp_layer_sequencer dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_new_data       (newData),
    .i_all_rows_sizes (rowsIn),
    .i_all_cols_sizes (colsIn),
    .o_busy           (busy),
    .o_w_rd_en        (wRdEn),
    .o_w_addr         (wAddr),
    .o_act_rd_addr    (actRdAddr),
    .o_act_bank       (actBank),
    .o_layer_idx      (layerIdx),
    .o_mac_en         (macEn),
    .o_acc_clr        (accClr),
    .o_acc_commit     (accCommit),
    .o_out_wr_addr    (outWrAddr),
    .o_output_ready   (outputReady),
    .o_cfg_err        (cfgErr),
    .o_perf_cycles    (perfCycles)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cfgValid();
    for (int l = 0; l < 2; l++)
      if (cfgRows[l] < 1 || cfgRows[l] > 9 || cfgCols[l] < 1 || cfgCols[l] > 9) return 1'b0;
    return (cfgCols[1] == cfgRows[0]);
  endfunction

  // Expected walk: LOAD, then per layer rows*cols issues plus two drain cycles, then DONE.
  task automatic buildModel();
    int t = 1;
    int a = 0;
    for (int i = 0; i < 256; i++) expRd[i] = 1'b0;
    for (int l = 0; l < 2; l++) begin
      for (int r = 0; r < cfgRows[l]; r++)
        for (int c = 0; c < cfgCols[l]; c++) begin
          expRd[t]    = 1'b1;
          expAddr[t]  = a % 256;
          expCol[t]   = c;
          expLayer[t] = l;
          expRow[t]   = r;
          expFirst[t] = (c == 0);
          expLast[t]  = (c == cfgCols[l] - 1);
          t++;
          a++;
        end
      t += 2;
    end
    lat = 2;
    for (int l = 0; l < 2; l++) lat += cfgRows[l] * cfgCols[l] + 2;
  endtask

  task automatic checkCycle(input int t);
    bit prev;
    checkOutput($sformatf("busy@%0d", t), busy, (t < lat));
    checkOutput($sformatf("output_ready@%0d", t), outputReady, (t == lat));
    checkOutput($sformatf("cfg_err@%0d", t), cfgErr, 0);
    checkOutput($sformatf("w_rd_en@%0d", t), wRdEn, expRd[t]);
    if (expRd[t]) begin
      checkOutput($sformatf("w_addr@%0d", t), wAddr, expAddr[t]);
      checkOutput($sformatf("act_rd_addr@%0d", t), actRdAddr, expCol[t]);
      checkOutput($sformatf("layer_idx@%0d", t), layerIdx, expLayer[t]);
      checkOutput($sformatf("act_bank@%0d", t), actBank, expLayer[t] % 2);
    end
    prev = (t > 0) && expRd[t-1];
    checkOutput($sformatf("mac_en@%0d", t), macEn, prev);
    checkOutput($sformatf("acc_clr@%0d", t), accClr, prev && expFirst[t-1]);
    checkOutput($sformatf("acc_commit@%0d", t), accCommit, prev && expLast[t-1]);
    if (prev) checkOutput($sformatf("out_wr_addr@%0d", t), outWrAddr, expRow[t-1]);
    if (t == lat) begin
`ifdef MLP_SEQ_PERF_EN
      checkOutput("perf_cycles", perfCycles, lat);
`else
      checkOutput("perf_cycles", perfCycles, 0);
`endif
    end
  endtask

  // Valid run from a negedge in IDLE; returns at the negedge where output_ready is expected.
  task automatic applyStimulus(input bit hold);
    buildModel();
    rowsIn  = {6'(cfgRows[1]), 6'(cfgRows[0])};
    colsIn  = {6'(cfgCols[1]), 6'(cfgCols[0])};
    newData = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int t = 0; t <= lat; t++) begin
      if (t == 0 && !hold) newData = 1'b0;
      if (t == 1) begin
        rowsIn = 12'($urandom);
        colsIn = 12'($urandom);
      end
      checkCycle(t);
      if (t == lat && hold) newData = 1'b0;
      if (t < lat) @(negedge clk);
    end
  endtask

  task automatic applyError();
    rowsIn  = {6'(cfgRows[1]), 6'(cfgRows[0])};
    colsIn  = {6'(cfgCols[1]), 6'(cfgCols[0])};
    newData = 1'b1;
    @(posedge clk);
    @(negedge clk);
    newData = 1'b0;
    for (int t = 0; t < 4; t++) begin
      checkOutput($sformatf("err_busy@%0d", t), busy, (t < 2));
      checkOutput($sformatf("err_cfg_err@%0d", t), cfgErr, (t == 2));
      checkOutput($sformatf("err_w_rd_en@%0d", t), wRdEn, 0);
      checkOutput($sformatf("err_output_ready@%0d", t), outputReady, 0);
      @(negedge clk);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_w_rd_en"}, wRdEn, 0);
    checkOutput({tag, "_w_addr"}, wAddr, 0);
    checkOutput({tag, "_act_rd_addr"}, actRdAddr, 0);
    checkOutput({tag, "_act_bank"}, actBank, 0);
    checkOutput({tag, "_layer_idx"}, layerIdx, 0);
    checkOutput({tag, "_mac_en"}, macEn, 0);
    checkOutput({tag, "_acc_clr"}, accClr, 0);
    checkOutput({tag, "_acc_commit"}, accCommit, 0);
    checkOutput({tag, "_out_wr_addr"}, outWrAddr, 0);
    checkOutput({tag, "_output_ready"}, outputReady, 0);
    checkOutput({tag, "_cfg_err"}, cfgErr, 0);
    checkOutput({tag, "_perf_cycles"}, perfCycles, 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst     = 1'b1;
    newData = 1'b0;
    rowsIn  = '0;
    colsIn  = '0;
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;
    @(negedge clk);

    cfgRows = '{3, 1}; cfgCols = '{2, 3};
    applyStimulus(1'b0);
    cfgRows = '{9, 1}; cfgCols = '{4, 9};
    applyStimulus(1'b0);

    cfgRows = '{3, 1}; cfgCols = '{2, 4};
    applyError();
    cfgRows = '{0, 3}; cfgCols = '{2, 0};
    applyError();
    cfgRows = '{10, 1}; cfgCols = '{2, 10};
    applyError();

    cfgRows = '{3, 1}; cfgCols = '{2, 3};
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("idle_after_run_busy", busy, 0);
    end

    cfgRows = '{9, 1}; cfgCols = '{4, 9};
    rowsIn  = {6'd1, 6'd9};
    colsIn  = {6'd9, 6'd4};
    newData = 1'b1;
    @(posedge clk);
    @(negedge clk);
    newData = 1'b0;
    for (int t = 0; t < 42; t++) @(negedge clk);
    checkOutput("pre_reset_layer", layerIdx, 1);
    rst = 1'b1;
    #1;
    checkAllZero("midrun_reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus(1'b0);

    for (int n = 0; n < 10; n++) begin
      cfgRows[0] = $urandom_range(1, 9);
      cfgRows[1] = $urandom_range(1, 9);
      cfgCols[0] = $urandom_range(1, 9);
      cfgCols[1] = cfgRows[0];
      if ($urandom_range(0, 3) == 0) begin
        cfgRows[$urandom_range(0, 1)] = $urandom_range(0, 12);
        cfgCols[$urandom_range(0, 1)] = $urandom_range(0, 12);
      end
      if (cfgValid()) applyStimulus(1'b0);
      else            applyError();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
